// File: rtl/dma_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_ctrl_pkg
// Purpose  : Shared definitions for the DMA burst sequencer: FSM state
//            encoding, the AXI 4 KB boundary constants and the maximum
//            burst-length derivation.
// Revision : 1.0 - initial release
// ============================================================================
package dma_burst_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CALC      = 3'd1,
        S_WAIT_IDLE = 3'd2,
        S_XFER      = 3'd3,
        S_BURST_END = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // A single AXI burst may never cross a 4 KB address boundary.
    localparam int unsigned c_boundary_bytes = 4096;
    localparam int unsigned c_boundary_bits  = 12;

    // Largest burst the AXI length field can describe (len field = beats-1).
    function automatic int unsigned max_burst(input int unsigned axi_len_w);
        return 32'd1 << axi_len_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_calc.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_calc
// Purpose  : Combinational burst sizing. Returns the number of beats for the
//            next burst as min(remaining words, max AXI burst, words left
//            before the next 4 KB boundary).
// Ports    : i_offset    - low 12 bits of the current byte address
//            i_remaining - words still to move in the descriptor
//            o_beats     - beats for the next burst (1 .. 2^AXI_LEN_W)
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_calc
    import dma_burst_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int LEN_W     = 16
) (
    input  logic [c_boundary_bits-1:0] i_offset,
    input  logic [LEN_W-1:0]           i_remaining,
    output logic [AXI_LEN_W:0]         o_beats
);

    localparam int unsigned c_bytes     = DATA_W / 8;
    localparam int unsigned c_max_burst = max_burst(AXI_LEN_W);

    logic [31:0] w_words_to_bnd;
    logic [31:0] w_rem;
    logic [31:0] w_cap;
    logic [31:0] w_beats;

    always_comb begin
        // Offset 0 yields a full 4 KB page worth of words.
        w_words_to_bnd = (c_boundary_bytes - 32'(i_offset)) / c_bytes;
        w_rem          = 32'(i_remaining);
        w_cap          = (w_rem < c_max_burst) ? w_rem : c_max_burst;
        w_beats        = (w_words_to_bnd < w_cap) ? w_words_to_bnd : w_cap;
        // Result never exceeds 2^AXI_LEN_W, so it fits in AXI_LEN_W+1 bits.
        o_beats        = (AXI_LEN_W+1)'(w_beats);
    end

endmodule
`default_nettype wire

// File: rtl/dma_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_ctrl
// Purpose  : Descriptor sequencer in front of the DMA block's native port.
//            Splits one descriptor into AXI bursts that respect the maximum
//            burst length and never cross 4 KB, programs dma_len per burst
//            and issues one native access per word, moving data between the
//            user stream/sink and the DMA block.
// Ports    : cfg_*        - descriptor launch (start, addr, len, dir)
//            busy/done/error - status towards the register file
//            s_*          - write-direction input stream
//            m_*          - read-direction output sink
//            dma_*        - native DMA port (valid/address/wdata/wstrb/rdata/
//                           rdy), burst length and DMA idle/error status
// Revision : 1.0 - initial release
// ============================================================================
module dma_burst_ctrl
    import dma_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int LEN_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    input  logic                  m_ready,
    output logic                  dma_valid,
    output logic [ADDR_W-1:0]     dma_address,
    output logic [DATA_W-1:0]     dma_wdata,
    output logic [DATA_W/8-1:0]   dma_wstrb,
    input  logic [DATA_W-1:0]     dma_rdata,
    input  logic                  dma_rdy,
    output logic [AXI_LEN_W-1:0]  dma_len,
    input  logic                  dma_idle,
    input  logic                  dma_error
);

    localparam int unsigned        c_bytes      = DATA_W / 8;
    localparam logic [ADDR_W-1:0]  c_stride     = ADDR_W'(c_bytes);
    localparam logic [ADDR_W-1:0]  c_align_mask = ADDR_W'(c_bytes - 1);
    localparam logic [AXI_LEN_W:0] c_one_beat   = (AXI_LEN_W+1)'(1);
    localparam logic [LEN_W-1:0]   c_one_word   = LEN_W'(1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_dir;
    logic                  r_error;
    logic [AXI_LEN_W:0]    r_beat_cnt;
    logic [AXI_LEN_W-1:0]  r_dma_len;
    // In write mode r_dma_valid doubles as the hold-register full flag.
    logic                  r_dma_valid;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_sink_valid;
    logic [DATA_W-1:0]     r_sink_data;

    logic [AXI_LEN_W:0]    w_beats;
    logic                  w_misaligned;
    logic                  w_beat_done;
    logic                  w_last_beat;
    logic                  w_abort;
    logic                  w_s_ready;
    logic                  w_s_fire;
    logic                  w_rd_issue;

    dma_burst_calc #(
        .DATA_W    (DATA_W),
        .AXI_LEN_W (AXI_LEN_W),
        .LEN_W     (LEN_W)
    ) u_calc (
        .i_offset    (r_addr[c_boundary_bits-1:0]),
        .i_remaining (r_remaining),
        .o_beats     (w_beats)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_misaligned = (cfg_addr & c_align_mask) != '0;
        w_beat_done  = r_dma_valid && dma_rdy;
        w_last_beat  = w_beat_done && (r_beat_cnt == c_one_beat);
        // Once an error is seen no new access is started; the one in flight
        // is still allowed to finish.
        w_abort      = r_error || dma_error;
        w_s_ready    = (r_state == S_XFER) && r_dir && !r_dma_valid && !w_abort;
        w_s_fire     = w_s_ready && s_valid;
        w_rd_issue   = (r_state == S_XFER) && !r_dir && !r_dma_valid &&
                       !r_sink_valid && !w_abort;

        unique case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_next = (w_misaligned || (cfg_len == '0)) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy   = 1'b1;
                w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                busy = 1'b1;
                if (dma_error) begin
                    w_next = S_DONE;
                end else if (dma_idle) begin
                    w_next = S_XFER;
                end
            end
            S_XFER: begin
                busy = 1'b1;
                if (w_abort && (!r_dma_valid || w_beat_done)) begin
                    w_next = S_DONE;
                end else if (w_last_beat) begin
                    w_next = S_BURST_END;
                end
            end
            S_BURST_END: begin
                busy = 1'b1;
                if (r_remaining != '0) begin
                    w_next = S_CALC;
                end else if (r_dir || !r_sink_valid) begin
                    // Read descriptors finish only after the sink drained.
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        s_ready = w_s_ready;
    end

    // ------------------------------------------------------------------------
    // Descriptor, burst and data-path registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_remaining  <= '0;
            r_dir        <= 1'b0;
            r_error      <= 1'b0;
            r_beat_cnt   <= '0;
            r_dma_len    <= '0;
            r_dma_valid  <= 1'b0;
            r_wdata      <= '0;
            r_sink_valid <= 1'b0;
            r_sink_data  <= '0;
        end else begin
            if ((r_state == S_IDLE) && cfg_start) begin
                r_addr      <= cfg_addr;
                r_remaining <= cfg_len;
                r_dir       <= cfg_dir;
                r_error     <= w_misaligned;
            end

            if (r_state == S_CALC) begin
                r_beat_cnt <= w_beats;
                r_dma_len  <= AXI_LEN_W'(w_beats - c_one_beat);
            end

            if (((r_state == S_WAIT_IDLE) || (r_state == S_XFER)) && dma_error) begin
                r_error <= 1'b1;
            end

            if (w_s_fire) begin
                r_wdata     <= s_data;
                r_dma_valid <= 1'b1;
            end

            if (w_rd_issue) begin
                r_dma_valid <= 1'b1;
            end

            if (r_sink_valid && m_ready) begin
                r_sink_valid <= 1'b0;
            end

            // Remaining words are retired per completed beat, so the count
            // is already final when the burst ends.
            if (w_beat_done) begin
                r_dma_valid <= 1'b0;
                r_addr      <= r_addr + c_stride;
                r_remaining <= r_remaining - c_one_word;
                r_beat_cnt  <= r_beat_cnt - c_one_beat;
                if (!r_dir) begin
                    r_sink_valid <= 1'b1;
                    r_sink_data  <= dma_rdata;
                end
            end
        end
    end

    always_comb begin
        error       = r_error;
        m_valid     = r_sink_valid;
        m_data      = r_sink_data;
        dma_valid   = r_dma_valid;
        dma_address = r_addr;
        dma_wdata   = r_wdata;
        dma_wstrb   = (r_dma_valid && r_dir) ? '1 : '0;
        dma_len     = r_dma_len;
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_burst_ctrl
// Purpose  : Directed self-checking bench for dma_burst_ctrl. A responder
//            completes each native access one cycle after dma_valid rises,
//            read data is a fixed function of the address and the write
//            stream carries a running word index.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dma_burst_ctrl;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          AXI_LEN_W = 8;
    localparam int          LEN_W     = 16;
    localparam logic [31:0] RD_KEY    = 32'hCAFE_0000;
    localparam logic [31:0] WR_BASE   = 32'hD000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_start;
    logic [ADDR_W-1:0]    cfg_addr;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_dir;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 s_valid;
    logic [DATA_W-1:0]    s_data;
    logic                 s_ready;
    logic                 m_valid;
    logic [DATA_W-1:0]    m_data;
    logic                 m_ready;
    logic                 dma_valid;
    logic [ADDR_W-1:0]    dma_address;
    logic [DATA_W-1:0]    dma_wdata;
    logic [DATA_W/8-1:0]  dma_wstrb;
    logic [DATA_W-1:0]    dma_rdata;
    logic                 dma_rdy = 1'b0;
    logic [AXI_LEN_W-1:0] dma_len;
    logic                 dma_idle;
    logic                 dma_error;

    always #5 clk = ~clk;

    dma_burst_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .AXI_LEN_W (AXI_LEN_W),
        .LEN_W     (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_addr    (cfg_addr),
        .cfg_len     (cfg_len),
        .cfg_dir     (cfg_dir),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .dma_valid   (dma_valid),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_wstrb   (dma_wstrb),
        .dma_rdata   (dma_rdata),
        .dma_rdy     (dma_rdy),
        .dma_len     (dma_len),
        .dma_idle    (dma_idle),
        .dma_error   (dma_error)
    );

    // Read data is derived from the address so order can be checked.
    assign dma_rdata = dma_address ^ RD_KEY;

    // Write stream: word k carries WR_BASE + k.
    logic [31:0] wr_word  = 32'd0;
    logic        acc_flag = 1'b0;
    assign s_data = WR_BASE + wr_word;

    always @(posedge clk) begin
        #1;
        if (acc_flag) wr_word = wr_word + 32'd1;
    end

    // ------------------------------------------------------------------------
    // Responder and logger (sampled on the falling edge)
    // ------------------------------------------------------------------------
    logic [31:0] acc_addr  [0:1023];
    logic [31:0] acc_wdata [0:1023];
    logic [3:0]  acc_strb  [0:1023];
    logic [7:0]  acc_len   [0:1023];
    logic [31:0] rd_log    [0:1023];
    int          acc_n    = 0;
    int          rd_n     = 0;
    int          done_n   = 0;
    int          viol_n   = 0;
    int          rdy_wait = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr  = 32'd0;
    logic [31:0] pend_wdata = 32'd0;

    always @(negedge clk) begin
        acc_flag = s_valid && s_ready;
        if (m_valid && m_ready && rd_n < 1024) begin
            rd_log[rd_n] = m_data;
            rd_n++;
        end
        if (done) done_n++;
        // At most one read outstanding: no request while the sink is full.
        if (dma_valid && m_valid) viol_n++;
        // A pending request must hold valid, address and data.
        if (pend && !rst && (!dma_valid || dma_address !== pend_addr ||
                             dma_wdata !== pend_wdata)) viol_n++;

        if (rst || !dma_valid || dma_rdy) begin
            dma_rdy  = 1'b0;
            rdy_wait = 0;
        end else if (rdy_wait >= 1) begin
            dma_rdy = 1'b1;
            if (acc_n < 1024) begin
                acc_addr[acc_n]  = dma_address;
                acc_wdata[acc_n] = dma_wdata;
                acc_strb[acc_n]  = dma_wstrb;
                acc_len[acc_n]   = dma_len;
            end
            acc_n++;
        end else begin
            rdy_wait++;
        end
        pend       = dma_valid && !dma_rdy && !rst;
        pend_addr  = dma_address;
        pend_wdata = dma_wdata;
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    int exp_w = 0;
    int a0, r0, d0, v, n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [15:0] l, input logic d);
        a0 = acc_n;
        r0 = rd_n;
        d0 = done_n;
        cfg_addr  = a;
        cfg_len   = l;
        cfg_dir   = d;
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done_n == d0 && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_done_pulse"}, done_n - d0, 1);
        tick(1);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_addr  = '0;
        cfg_len   = '0;
        cfg_dir   = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        dma_idle  = 1'b1;
        dma_error = 1'b0;
        tick(3);
        check("rst_busy",      32'(busy), 0);
        check("rst_done",      32'(done), 0);
        check("rst_error",     32'(error), 0);
        check("rst_dma_valid", 32'(dma_valid), 0);
        check("rst_dma_len",   32'(dma_len), 0);
        check("rst_m_valid",   32'(m_valid), 0);
        check("rst_s_ready",   32'(s_ready), 0);
        rst = 1'b0;
        tick(2);

        // Single write burst of 4 words.
        s_valid = 1'b1;
        m_ready = 1'b1;
        launch(32'h1000, 16'd4, 1'b1);
        wait_done("w4", 200);
        check("w4_count", acc_n - a0, 4);
        v = 0;
        for (int i = 0; i < 4; i++) begin
            if (acc_addr[a0+i] !== 32'h1000 + 32'(4*i)) v++;
            if (acc_wdata[a0+i] !== WR_BASE + 32'(exp_w)) v++;
            exp_w++;
            if (acc_strb[a0+i] !== 4'hF) v++;
            if (acc_len[a0+i] !== 8'd3) v++;
        end
        check("w4_beats", v, 0);
        check("w4_busy_after", 32'(busy), 0);
        check("w4_error", 32'(error), 0);

        // Read across a 4 KB boundary: 2 + 4 beats.
        launch(32'h0FF8, 16'd6, 1'b0);
        wait_done("r6", 300);
        check("r6_count", acc_n - a0, 6);
        v = 0;
        for (int i = 0; i < 6; i++) begin
            if (acc_addr[a0+i] !== 32'h0FF8 + 32'(4*i)) v++;
            if (acc_len[a0+i] !== ((i < 2) ? 8'd1 : 8'd3)) v++;
            if (acc_strb[a0+i] !== 4'h0) v++;
        end
        check("r6_beats", v, 0);
        check("r6_sink_count", rd_n - r0, 6);
        v = 0;
        for (int i = 0; i < 6; i++) begin
            if (rd_log[r0+i] !== ((32'h0FF8 + 32'(4*i)) ^ RD_KEY)) v++;
        end
        check("r6_sink_data", v, 0);

        // Long write: 256 + 44 beats; no access while the DMA block is busy.
        dma_idle = 1'b0;
        launch(32'h2000, 16'd300, 1'b1);
        tick(6);
        check("w300_hold_busy",  32'(busy), 1);
        check("w300_hold_noacc", acc_n - a0, 0);
        check("w300_hold_valid", 32'(dma_valid), 0);
        dma_idle = 1'b1;
        wait_done("w300", 2000);
        check("w300_count", acc_n - a0, 300);
        v = 0;
        for (int i = 0; i < 300; i++) begin
            if (acc_addr[a0+i] !== 32'h2000 + 32'(4*i)) v++;
            if (acc_len[a0+i] !== ((i < 256) ? 8'd255 : 8'd43)) v++;
            if (acc_wdata[a0+i] !== WR_BASE + 32'(exp_w)) v++;
            exp_w++;
        end
        check("w300_beats", v, 0);

        // Read with the sink stalled for 10 cycles.
        m_ready = 1'b0;
        launch(32'h3000, 16'd4, 1'b0);
        tick(10);
        check("rstall_one_outstanding", acc_n - a0, 1);
        check("rstall_m_valid",   32'(m_valid), 1);
        check("rstall_valid_low", 32'(dma_valid), 0);
        check("rstall_m_data",    m_data, 32'h3000 ^ RD_KEY);
        m_ready = 1'b1;
        wait_done("rstall", 200);
        check("rstall_count", acc_n - a0, 4);
        check("rstall_sink_count", rd_n - r0, 4);
        v = 0;
        for (int i = 0; i < 4; i++) begin
            if (rd_log[r0+i] !== ((32'h3000 + 32'(4*i)) ^ RD_KEY)) v++;
        end
        check("rstall_sink_data", v, 0);

        // Misaligned address, then zero length.
        launch(32'h1002, 16'd4, 1'b1);
        check("mis_done_now", 32'(done), 1);
        check("mis_error",    32'(error), 1);
        check("mis_busy",     32'(busy), 0);
        wait_done("mis", 10);
        check("mis_noacc",    acc_n - a0, 0);
        check("mis_sticky",   32'(error), 1);
        launch(32'h1000, 16'd0, 1'b1);
        check("len0_done_now",      32'(done), 1);
        check("len0_error_cleared", 32'(error), 0);
        wait_done("len0", 10);
        check("len0_noacc", acc_n - a0, 0);

        // dma_error while beat 2 of 8 is in flight.
        launch(32'h4000, 16'd8, 1'b1);
        n = 0;
        while (!(dma_valid && acc_n == a0 + 1) && n < 100) begin
            tick(1);
            n++;
        end
        check("err_reach_beat2", acc_n - a0, 1);
        dma_error = 1'b1;
        tick(1);
        dma_error = 1'b0;
        wait_done("err", 50);
        check("err_count", acc_n - a0, 2);
        check("err_flag",  32'(error), 1);
        check("err_wdata0", acc_wdata[a0],   WR_BASE + 32'(exp_w));
        check("err_wdata1", acc_wdata[a0+1], WR_BASE + 32'(exp_w + 1));
        exp_w += 2;
        tick(3);
        check("err_stream_words", wr_word, 32'(exp_w));

        // Reset in the middle of a burst.
        launch(32'h5000, 16'd8, 1'b1);
        n = 0;
        while (!(dma_valid && acc_n == a0 + 2) && n < 100) begin
            tick(1);
            n++;
        end
        check("rstmid_reach", acc_n - a0, 2);
        d0  = done_n;
        rst = 1'b1;
        tick(1);
        check("rstmid_valid", 32'(dma_valid), 0);
        check("rstmid_busy",  32'(busy), 0);
        rst = 1'b0;
        tick(5);
        check("rstmid_no_done", done_n - d0, 0);
        check("rstmid_s_ready", 32'(s_ready), 0);

        check("protocol_monitor", viol_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
